// File: rtl/shift_arbiter_pkg.sv
// rtl/shift_arbiter_pkg.sv - shared constants, types and helpers for the shift arbiter
package shift_arbiter_pkg;

  // Direction encoding of req_dir
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Default datapath configuration; the response record is sized for it
  localparam int RSP_WIDTH   = 8;
  localparam int RSP_ID_BITS = 2;

  // Requester tag width; a single requester still needs one bit of tag
  function automatic int id_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // One response entry: shifted result plus the requester that produced it
  typedef struct packed {
    logic [RSP_WIDTH-1:0]   data;
    logic [RSP_ID_BITS-1:0] id;
  } rsp_t;

endpackage

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - combinational left-logical / right-arithmetic shifter
module barrel_shifter
  import shift_arbiter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SHIFT_BITS = 3
) (
  input  logic [WIDTH-1:0]      data_i,
  input  logic [SHIFT_BITS-1:0] shamt_i,
  input  logic                  dir_i,
  output logic [WIDTH-1:0]      data_o
);

  logic signed [WIDTH-1:0] sdata;
  logic signed [WIDTH-1:0] right_res;
  logic        [WIDTH-1:0] left_res;

  // Right result is kept in its own signed net so the sign fill survives
  assign sdata     = data_i;
  assign right_res = sdata >>> shamt_i;
  assign left_res  = data_i << shamt_i;

  // Select the shift direction
  always_comb begin
    data_o = left_res;
    if (dir_i == DIR_RIGHT) begin
      data_o = right_res;
    end
  end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin priority pick starting just above the pointer
module rr_pick
  import shift_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ID_BITS = id_bits(NREQ)
) (
  input  logic [NREQ-1:0]    valid_i,
  input  logic [ID_BITS-1:0] ptr_i,
  output logic [NREQ-1:0]    grant_o,
  output logic [ID_BITS-1:0] idx_o,
  output logic               any_o
);

  // Scan upward with wrap from ptr+1; the first valid requester wins
  always_comb begin
    int j;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!any_o && valid_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = ID_BITS'(j);
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one barrel shifter among requesters
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SHIFT_BITS = 3,
  parameter int NREQ       = 4,
  parameter int ID_BITS    = id_bits(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*WIDTH-1:0]      req_data,
  input  logic [NREQ*SHIFT_BITS-1:0] req_shamt,
  input  logic [NREQ-1:0]            req_dir,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [ID_BITS-1:0]         rsp_id
);

  // rsp_valid is the state bit itself
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     data_q;
  logic [ID_BITS-1:0]   id_q;
  logic [ID_BITS-1:0]   ptr_q;
  logic [ID_BITS-1:0]   ptr_d;

  logic [NREQ-1:0]       grant;
  logic [ID_BITS-1:0]    grant_idx;
  logic                  grant_any;
  logic                  slot_free;
  logic                  accept;
  logic [WIDTH-1:0]      sel_data;
  logic [SHIFT_BITS-1:0] sel_shamt;
  logic                  sel_dir;
  logic [WIDTH-1:0]      shift_out;

  rr_pick #(
    .NREQ    (NREQ),
    .ID_BITS (ID_BITS)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  // Grant only when the output slot is empty or draining this cycle
  always_comb begin
    slot_free = (state_q == S_EMPTY) || rsp_ready;
    req_ready = '0;
    if (rst_n && slot_free) begin
      req_ready = grant;
    end
    accept = rst_n && slot_free && grant_any;
    ptr_d  = accept ? grant_idx : ptr_q;
  end

  // Route the granted requester's operands into the shared shifter
  always_comb begin
    sel_data  = req_data[int'(grant_idx)*WIDTH +: WIDTH];
    sel_shamt = req_shamt[int'(grant_idx)*SHIFT_BITS +: SHIFT_BITS];
    sel_dir   = req_dir[grant_idx];
  end

  barrel_shifter #(
    .WIDTH      (WIDTH),
    .SHIFT_BITS (SHIFT_BITS)
  ) u_shift (
    .data_i  (sel_data),
    .shamt_i (sel_shamt),
    .dir_i   (sel_dir),
    .data_o  (shift_out)
  );

  // Output slot state machine; an accept always (re)loads, a bare drain empties
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= ID_BITS'(NREQ - 1);
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        state_q <= S_FULL;
        data_q  <= shift_out;
        id_q    <= grant_idx;
      end else if (rsp_ready) begin
        state_q <= S_EMPTY;
      end
    end
  end

  assign rsp_valid = (state_q == S_FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;

endmodule
